// File: rtl/jump_field_encoder.sv
// Encodes an absolute jump target into a J/JAL instruction word, with alignment and
// 256 MB region checks, returned over a valid/ready handshake with saturating counters.
module jump_field_encoder #(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [31:0]            pc4_i,
    input  logic [31:0]            target_i,
    input  logic                   link_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [31:0]            instr_o,
    output logic                   err_align_o,
    output logic                   err_region_o,
    output logic [COUNT_WIDTH-1:0] count_ok_o,
    output logic [COUNT_WIDTH-1:0] count_err_o
);

    typedef enum logic [1:0] {StIdle, StCheck, StResp} state_e;

    state_e state_q, state_d;

    logic [3:0]             pc4_hi_q;
    logic [31:0]            target_q;
    logic                   link_q;
    logic [31:0]            instr_q;
    logic                   err_align_q, err_region_q;
    logic [COUNT_WIDTH-1:0] count_ok_q, count_ok_d;
    logic [COUNT_WIDTH-1:0] count_err_q, count_err_d;

    logic        align_err, region_err;
    logic [31:0] encoded;

    // Only the region nibble of PC+4 matters; the low bits are intentionally dropped.
    logic unused_pc4_low;
    assign unused_pc4_low = ^pc4_i[27:0];

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req_valid_i) state_d = StCheck;
            StCheck: state_d = StResp;
            StResp:  if (rsp_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decode the state register only
    always_comb begin
        req_ready_o = (state_q == StIdle);
        rsp_valid_o = (state_q == StResp);
    end

    always_comb begin
        align_err  = |target_q[1:0];
        region_err = (target_q[31:28] != pc4_hi_q);
        encoded    = {5'b00001, link_q, target_q[27:2]};
    end

    always_comb begin
        count_ok_d  = count_ok_q;
        count_err_d = count_err_q;
        if (state_q == StResp && rsp_ready_i) begin
            if (err_align_q || err_region_q) begin
                if (count_err_q != '1) count_err_d = count_err_q + COUNT_WIDTH'(1);
            end else begin
                if (count_ok_q != '1) count_ok_d = count_ok_q + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc4_hi_q     <= '0;
            target_q     <= '0;
            link_q       <= 1'b0;
            instr_q      <= '0;
            err_align_q  <= 1'b0;
            err_region_q <= 1'b0;
            count_ok_q   <= '0;
            count_err_q  <= '0;
        end else begin
            if (state_q == StIdle && req_valid_i) begin
                pc4_hi_q <= pc4_i[31:28];
                target_q <= target_i;
                link_q   <= link_i;
            end
            if (state_q == StCheck) begin
                err_align_q  <= align_err;
                err_region_q <= region_err;
                instr_q      <= (align_err || region_err) ? 32'h0 : encoded;
            end
            count_ok_q  <= count_ok_d;
            count_err_q <= count_err_d;
        end
    end

    assign instr_o      = instr_q;
    assign err_align_o  = err_align_q;
    assign err_region_o = err_region_q;
    assign count_ok_o   = count_ok_q;
    assign count_err_o  = count_err_q;

endmodule

// File: tb/tb_jump_field_encoder.sv
// Bench for jump_field_encoder: a 16-bit-counter and a 2-bit-counter instance share stimulus
// and are checked each cycle against a transaction-level model plus literal expectations.
module tb_jump_field_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] pc4 = '0;
    logic [31:0] target = '0;
    logic        link = 1'b0;
    logic        rsp_ready = 1'b0;

    logic        req_ready_w, rsp_valid_w, ea_w, er_w;
    logic [31:0] instr_w;
    logic [15:0] ok_w, err_w;
    logic        req_ready_s, rsp_valid_s, ea_s, er_s;
    logic [31:0] instr_s;
    logic [1:0]  ok_s, err_s;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    jump_field_encoder #(.COUNT_WIDTH(16)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready_w),
        .pc4_i(pc4), .target_i(target), .link_i(link), .rsp_valid_o(rsp_valid_w),
        .rsp_ready_i(rsp_ready), .instr_o(instr_w), .err_align_o(ea_w), .err_region_o(er_w),
        .count_ok_o(ok_w), .count_err_o(err_w)
    );

    jump_field_encoder #(.COUNT_WIDTH(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready_s),
        .pc4_i(pc4), .target_i(target), .link_i(link), .rsp_valid_o(rsp_valid_s),
        .rsp_ready_i(rsp_ready), .instr_o(instr_s), .err_align_o(ea_s), .err_region_o(er_s),
        .count_ok_o(ok_s), .count_err_o(err_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bad_align(input logic [31:0] t);
        return (t % 4) != 0;
    endfunction

    function automatic bit bad_region(input logic [31:0] p, input logic [31:0] t);
        return (t / 32'h1000_0000) != (p / 32'h1000_0000);
    endfunction

    function automatic logic [31:0] encode(input logic [31:0] p, input logic [31:0] t,
                                           input bit l);
        int unsigned op;
        op = l ? 3 : 2;
        if (bad_align(t) || bad_region(p, t)) return 32'h0;
        return op * 32'h0400_0000 + (t % 32'h1000_0000) / 4;
    endfunction

    function automatic int sat(input int v, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    // Transaction-level model: a request is pending from acceptance until its response is taken
    bit          m_busy, m_shown, m_ea, m_er, m_link;
    logic [31:0] m_pc4, m_tgt, m_instr;
    int          m_ok, m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 0; m_shown <= 0; m_ea <= 0; m_er <= 0; m_instr <= '0;
            m_ok <= 0; m_err <= 0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy <= 1; m_shown <= 0; m_pc4 <= pc4; m_tgt <= target; m_link <= link;
            end
        end else if (!m_shown) begin
            m_shown <= 1;
            m_instr <= encode(m_pc4, m_tgt, m_link);
            m_ea    <= bad_align(m_tgt);
            m_er    <= bad_region(m_pc4, m_tgt);
        end else if (rsp_ready) begin
            m_busy <= 0;
            if (m_ea || m_er) m_err <= m_err + 1;
            else m_ok <= m_ok + 1;
        end
    end

    always @(negedge clk) begin
        chk("req_ready", 32'(req_ready_w), 32'(!m_busy));
        chk("rsp_valid", 32'(rsp_valid_w), 32'(m_busy && m_shown));
        chk("instr", instr_w, m_instr);
        chk("err_align", 32'(ea_w), 32'(m_ea));
        chk("err_region", 32'(er_w), 32'(m_er));
        chk("count_ok", 32'(ok_w), 32'(sat(m_ok, 16)));
        chk("count_err", 32'(err_w), 32'(sat(m_err, 16)));
        chk("sat_req_ready", 32'(req_ready_s), 32'(!m_busy));
        chk("sat_instr", instr_s, m_instr);
        chk("sat_count_ok", 32'(ok_s), 32'(sat(m_ok, 2)));
        chk("sat_count_err", 32'(err_s), 32'(sat(m_err, 2)));
    end

    // One transaction; hold>0 keeps rsp_ready low for that many cycles in the response phase.
    task automatic send(input logic [31:0] p, input logic [31:0] t, input bit l,
                        input int hold, output logic [31:0] ins, output logic ea,
                        output logic er);
        int edges;
        rsp_ready = (hold == 0);
        req_valid = 1'b1; pc4 = p; target = t; link = l;
        @(posedge clk); #1;
        req_valid = 1'b0;
        edges = 1;
        while (!rsp_valid_w && edges < 10) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("latency_edges", 32'(edges), 32'd2);
        ins = instr_w; ea = ea_w; er = er_w;
        for (int i = 0; i < hold; i++) begin
            req_valid = ~req_valid; pc4 = $urandom; target = $urandom; link = ~link;
            @(posedge clk); #1;
            chk("hold_req_ready", 32'(req_ready_w), 32'd0);
            chk("hold_rsp_valid", 32'(rsp_valid_w), 32'd1);
            chk("hold_instr", instr_w, ins);
            chk("hold_flags", {30'd0, ea_w, er_w}, {30'd0, ea, er});
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_req_ready", 32'(req_ready_w), 32'd1);
        chk("post_rsp_valid", 32'(rsp_valid_w), 32'd0);
        rsp_ready = 1'b0;
    endtask

    logic [31:0] ins;
    logic        ea, er;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_instr", instr_w, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid_w), 32'd0);
        rst = 1'b0;
        chk("rst_req_ready", 32'(req_ready_w), 32'd1);
        chk("rst_count_ok", 32'(ok_w), 32'd0);

        send(32'h0040_0004, 32'h0040_0100, 1'b0, 0, ins, ea, er);
        chk("j_instr", ins, 32'h0810_0040);
        chk("j_flags", {30'd0, ea, er}, 32'd0);
        chk("j_count_ok", 32'(ok_w), 32'd1);

        send(32'h0040_0004, 32'h0040_0100, 1'b1, 0, ins, ea, er);
        chk("jal_instr", ins, 32'h0C10_0040);
        chk("jal_regen", {32'h0040_0004 & 32'hF000_0000} | {4'h0, ins[25:0], 2'b00},
            32'h0040_0100);

        send(32'h0040_0004, 32'h0040_0102, 1'b0, 0, ins, ea, er);
        chk("mis_flags", {30'd0, ea, er}, 32'd2);
        chk("mis_instr", ins, 32'h0);
        chk("mis_count_err", 32'(err_w), 32'd1);
        chk("mis_count_ok", 32'(ok_w), 32'd2);

        send(32'h1000_0000, 32'h2000_0003, 1'b1, 0, ins, ea, er);
        chk("region_flags", {30'd0, ea, er}, 32'd3);
        chk("region_instr", ins, 32'h0);

        send(32'h3000_0008, 32'h3ABC_DEF0, 1'b1, 5, ins, ea, er);
        chk("bp_instr", ins, 32'h0EAF_37BC);
        chk("bp_count_ok", 32'(ok_w), 32'd3);

        // Reset in the middle of the check phase
        req_valid = 1'b1; pc4 = 32'h0040_0004; target = 32'h0040_0100; link = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_instr", instr_w, 32'h0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid_w), 32'd0);
        chk("mid_rst_counts", {ok_w, err_w}, 32'h0);
        chk("mid_rst_flags", {30'd0, ea_w, er_w}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_req_ready", 32'(req_ready_w), 32'd1);

        for (int i = 0; i < 5; i++) begin
            send(32'h0040_0004, 32'h0040_0100 + 32'(i * 4), 1'b0, 0, ins, ea, er);
            chk("after_rst_instr", ins, 32'h0810_0040 + 32'(i));
        end
        chk("sat_ok_literal", 32'(ok_s), 32'd3);
        chk("wide_ok_literal", 32'(ok_w), 32'd5);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jump_field_encoder.md
# jump_field_encoder

Sequential encoder for the multi-cycle CPU that converts an absolute 32-bit jump target back into a J/JAL instruction word. Given the PC+4 of the jump slot and a desired target, it produces the 26-bit instr_index field, checks that the target is word-aligned and lies in the same 256 MB region as PC+4, and returns the encoded instruction over a valid/ready handshake. It is used by the on-chip loader/debug path to patch jump instructions into instruction memory. For every error-free result, the jump address generator applied to its output reproduces the original target.

## Interface
- COUNT_WIDTH, 16, width of the success and error counters.
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Req_valid  in  1  request present.
- Req_ready  out  1  unit can accept a request.
- PC4  in  32  PC+4 of the jump instruction's own slot.
- Target  in  32  desired absolute jump target.
- Link  in  1  1 = encode JAL (opcode 6'b000011), 0 = encode J (opcode 6'b000010).
- Rsp_valid  out  1  response present.
- Rsp_ready  in  1  consumer accepts the response.
- Instr_out  out  32  encoded instruction; 32'h0000_0000 on error.
- Err_align  out  1  Target[1:0] != 0.
- Err_region  out  1  Target[31:28] != PC4[31:28].
- Count_ok  out  COUNT_WIDTH  number of error-free responses accepted; saturating.
- Count_err  out  COUNT_WIDTH  number of error responses accepted; saturating.

## Operation
- States:
  - IDLE: Req_ready=1, Rsp_valid=0.
  - CHECK: Req_ready=0, Rsp_valid=0.
  - RESP: Req_ready=0, Rsp_valid=1.
- State transitions:
  - IDLE -> CHECK when Req_valid && Req_ready. PC4, Target and Link are latched on that edge; the inputs are don't-care afterwards.
  - CHECK -> RESP unconditionally. On this edge the unit registers Err_align, Err_region and Instr_out.
  - RESP -> IDLE when Rsp_ready. On this edge it increments Count_ok if no error flag is set, otherwise Count_err.
- Encoding:
  - Instr_out = {opcode, Target[27:2]}.
  - If Err_align or Err_region is set, Instr_out = 0 (NOP). Both flags may be set together.
- Req_valid in CHECK or RESP is ignored; the request is not consumed (Req_ready=0).
- Response outputs hold stable in RESP until the response is accepted.
- Instr_out, Err_align and Err_region keep their last values in IDLE and CHECK.
- Counters:
  - They stop at 2^COUNT_WIDTH-1 and never wrap.
  - Only Reset clears them.
- Reset, asserted at any time:
  - State goes to IDLE immediately, without waiting for a clock edge.
  - Any in-flight transaction is dropped and not counted.
  - Instr_out=0, Err_align=0, Err_region=0, Rsp_valid=0, Count_ok=0, Count_err=0.
  - Req_ready=1 as soon as Reset is deasserted.

## Timing
- Request accepted at edge N: CHECK during cycle N..N+1, Rsp_valid=1 after edge N+1.
- Latency from acceptance to first Rsp_valid is 2 edges; the response is valid in the cycle following edge N+1.
- Minimum spacing between accepted requests is 3 cycles, with Rsp_ready tied high.
- The response is accepted on the same edge Rsp_valid && Rsp_ready is seen. Req_ready returns high after that edge; there is no same-cycle bypass.
- All outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.

## Test plan
- J encode:
  - Stimulus: PC4=0x0040_0004, Target=0x0040_0100, Link=0.
  - Response: Instr_out=0x0810_0040, no error flags, Rsp_valid exactly 2 edges after acceptance, Count_ok=1.
- JAL encode:
  - Stimulus: same as above with Link=1.
  - Response: Instr_out=0x0C10_0040.
  - Check: feeding Instr_out[25:0]<<2 with PC4 through the jump address generator returns 0x0040_0100.
- Misaligned target:
  - Stimulus: Target=0x0040_0102.
  - Response: Err_align=1, Err_region=0, Instr_out=0, Count_err=1, Count_ok unchanged.
- Region crossing:
  - Stimulus: PC4=0x1000_0000, Target=0x2000_0003.
  - Response: Err_align=1 and Err_region=1, Instr_out=0.
- Backpressure and handshake:
  - Hold Rsp_ready=0 for 5 cycles in RESP while toggling Req_valid and changing PC4/Target.
  - Response: Instr_out and flags stay stable, Req_ready=0 throughout, no new request is latched. Raising Rsp_ready completes the transfer and Req_ready=1 on the next cycle.
- Reset and saturation:
  - Assert Reset mid-CHECK. Response: all outputs read 0 before the next edge, Req_ready=1 after release, and the next request encodes correctly.
  - With COUNT_WIDTH=2, complete 5 good requests. Response: Count_ok=3.
